// File: rtl/seg7_pkg.sv
// Shared types, constants and the hex-to-7-segment decoder for the scan controller.
package seg7_pkg;

  localparam logic [6:0] SEG_OFF = 7'b1111111;

  typedef enum logic {ST_DEAD, ST_DRIVE} scan_state_t;

  // Active-low {g,f,e,d,c,b,a}; b and d are lowercase glyphs.
  function automatic logic [6:0] seg_decode(input logic [3:0] v);
    logic [6:0] s;
    s = SEG_OFF;
    case (v)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0010000;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;
      4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;
      4'hF: s = 7'b0001110;
      default: s = SEG_OFF;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/seg7_scan_ctrl_if.sv
// Load handshake between the datapath (master) and the scan controller (slave).
interface seg7_scan_ctrl_if #(
  parameter int unsigned NUM_DIGITS = 4
);
  logic                    load_valid;
  logic                    load_ready;
  logic [4*NUM_DIGITS-1:0] load_data;

  modport master (output load_valid, output load_data, input  load_ready);
  modport slave  (input  load_valid, input  load_data, output load_ready);
endinterface

// File: rtl/seg7_slot_timer.sv
// Slot counter (0..TICK_DIV-1) and digit index; flags slot/frame boundaries and dead time.
module seg7_slot_timer #(
  parameter int unsigned NUM_DIGITS  = 4,
  parameter int unsigned TICK_DIV    = 50000,
  parameter int unsigned DEAD_CYCLES = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  output logic                          wrap,
  output logic                          frame_boundary,
  output logic                          in_dead,
  output logic                          dead_end,
  output logic                          slot_start,
  output logic [$clog2(NUM_DIGITS)-1:0] idx
);
  localparam int unsigned CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned IW = $clog2(NUM_DIGITS);

  logic [CW-1:0] cnt;

  assign wrap           = (cnt == CW'(TICK_DIV - 1));
  assign frame_boundary = wrap && (idx == IW'(NUM_DIGITS - 1));
  assign in_dead        = (cnt < CW'(DEAD_CYCLES));
  assign dead_end       = (cnt == CW'(DEAD_CYCLES - 1));
  assign slot_start     = (cnt == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      idx <= '0;
    end else if (wrap) begin
      cnt <= '0;
      idx <= (idx == IW'(NUM_DIGITS - 1)) ? '0 : idx + 1'b1;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Time-multiplexed 7-segment scan controller with frame-aligned value commit.
// Optional: define LEAD_ZERO_BLANK_EN to blank leading zero digits (digit 0 always shows).
module seg7_scan_ctrl
  import seg7_pkg::*;
#(
  parameter int unsigned NUM_DIGITS  = 4,
  parameter int unsigned TICK_DIV    = 50000,
  parameter int unsigned DEAD_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  seg7_scan_ctrl_if.slave       load,
  input  logic [NUM_DIGITS-1:0] blank_mask,
  output logic [6:0]            seg,
  output logic [NUM_DIGITS-1:0] an,
  output logic                  frame_start
);
  localparam int unsigned IW = $clog2(NUM_DIGITS);
  localparam int unsigned DW = 4 * NUM_DIGITS;

  logic          wrap, frame_boundary, in_dead, dead_end, slot_start;
  logic [IW-1:0] idx;

  scan_state_t   state;
  logic [DW-1:0] disp, pend_data;
  logic          pending;
  logic [NUM_DIGITS-1:0] lz, blank;

  seg7_slot_timer #(
    .NUM_DIGITS  (NUM_DIGITS),
    .TICK_DIV    (TICK_DIV),
    .DEAD_CYCLES (DEAD_CYCLES)
  ) u_timer (
    .clk            (clk),
    .rst_n          (rst_n),
    .wrap           (wrap),
    .frame_boundary (frame_boundary),
    .in_dead        (in_dead),
    .dead_end       (dead_end),
    .slot_start     (slot_start),
    .idx            (idx)
  );

  assign load.load_ready = !pending;

  // Commit has priority: a transfer on the boundary edge only sets pending.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      disp      <= '0;
      pend_data <= '0;
      pending   <= 1'b0;
    end else if (frame_boundary && pending) begin
      disp    <= pend_data;
      pending <= 1'b0;
    end else if (load.load_valid && !pending) begin
      pend_data <= load.load_data;
      pending   <= 1'b1;
    end
  end

`ifdef LEAD_ZERO_BLANK_EN
  // Scan from the top nibble down; a digit is blank while everything above and including it is 0.
  always_comb begin
    logic zrun;
    lz   = '0;
    zrun = 1'b1;
    for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
      zrun = zrun && (disp[(NUM_DIGITS-1-k)*4 +: 4] == 4'h0);
      lz[NUM_DIGITS-1-k] = zrun && ((NUM_DIGITS-1-k) != 0);
    end
  end
`else
  assign lz = '0;
`endif

  assign blank = blank_mask | lz;

  // State tracks the counter: DEAD from slot start until DEAD_CYCLES elapse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_DEAD;
      an          <= '1;
      seg         <= SEG_OFF;
      frame_start <= 1'b0;
    end else begin
      if (wrap)
        state <= ST_DEAD;
      else if (in_dead && dead_end)
        state <= ST_DRIVE;

      frame_start <= slot_start && (idx == '0);

      if (state == ST_DRIVE) begin
        an  <= ~(NUM_DIGITS'(1) << idx);
        seg <= blank[idx] ? SEG_OFF : seg_decode(disp[idx*4 +: 4]);
      end else begin
        an  <= '1;
        seg <= SEG_OFF;
      end
    end
  end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Randomized and directed bench for seg7_scan_ctrl against a cycle-count reference model.
module tb_seg7_scan_ctrl;
  localparam int unsigned ND = 4;
  localparam int unsigned TD = 4;
  localparam int unsigned DC = 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic [ND-1:0] blank_mask = '0;
  logic [6:0]    seg;
  logic [ND-1:0] an;
  logic          frame_start;

  seg7_scan_ctrl_if #(.NUM_DIGITS(ND)) lif ();

  seg7_scan_ctrl #(
    .NUM_DIGITS  (ND),
    .TICK_DIV    (TD),
    .DEAD_CYCLES (DC)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .load        (lif),
    .blank_mask  (blank_mask),
    .seg         (seg),
    .an          (an),
    .frame_start (frame_start)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  logic [6:0] dec [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                           7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  // Model: cycles since reset release determine slot position; display/pending follow the handshake rules.
  int          t = 0;
  logic [15:0] m_disp = '0;
  logic [15:0] m_pd = '0;
  bit          m_pend = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h (t=%0d)", tag, got, exp, t);
    end
  endtask

  task automatic model_reset();
    t = 0;
    m_disp = '0;
    m_pd = '0;
    m_pend = 1'b0;
  endtask

  task automatic step();
    int c, d;
    logic [6:0] es;
    logic [3:0] ea;
    logic [3:0] nib;
    logic [15:0] above;
    bit blk, efs;
    @(posedge clk);
    c = t % TD;
    d = (t / TD) % ND;
    efs = (t % (TD * ND) == 0);
    if (c < DC) begin
      ea = 4'hF;
      es = 7'h7F;
    end else begin
      ea = 4'hF & ~(4'b0001 << d);
      nib = m_disp[4*d +: 4];
      above = m_disp >> (4 * d);
      blk = blank_mask[d];
`ifdef LEAD_ZERO_BLANK_EN
      if (d != 0 && above == 16'h0) blk = 1'b1;
`endif
      es = blk ? 7'h7F : dec[nib];
    end
    if (c == TD - 1 && d == ND - 1 && m_pend) begin
      m_disp = m_pd;
      m_pend = 1'b0;
    end else if (lif.load_valid && !m_pend) begin
      m_pd = lif.load_data;
      m_pend = 1'b1;
    end
    t++;
    @(negedge clk);
    chk("an", 32'(an), 32'(ea));
    chk("seg", 32'(seg), 32'(es));
    chk("frame_start", 32'(frame_start), 32'(efs));
    chk("load_ready", 32'(lif.load_ready), 32'(!m_pend));
  endtask

  initial begin
    bit ok;
    lif.load_valid = 1'b0;
    lif.load_data  = '0;

    #1 rst_n = 1'b0;
    #2;
    chk("rst_seg", 32'(seg), 32'h7F);
    chk("rst_an", 32'(an), 32'hF);
    chk("rst_ready", 32'(lif.load_ready), 32'h1);
    chk("rst_fs", 32'(frame_start), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();

    repeat (40) step();

    // Load while idle, then a competing load while pending.
    lif.load_valid = 1'b1; lif.load_data = 16'h12A8;
    step();
    lif.load_data = 16'hFFFF;
    repeat (10) step();
    lif.load_valid = 1'b0;
    repeat (40) step();

    // Transfer exactly on the boundary edge.
    ok = 1'b0;
    for (int i = 0; i < 64 && !ok; i++) begin
      if (!m_pend && (t % (TD * ND)) == TD * ND - 1) ok = 1'b1;
      else step();
    end
    chk("boundary_wait", 32'(ok), 32'h1);
    lif.load_valid = 1'b1; lif.load_data = 16'h4321;
    step();
    lif.load_valid = 1'b0;
    repeat (40) step();

    blank_mask = 4'b0100;
    repeat (20) step();
    blank_mask = 4'b0000;

    lif.load_valid = 1'b1; lif.load_data = 16'h0050;
    step();
    lif.load_valid = 1'b0;
    repeat (40) step();

    for (int i = 0; i < 400; i++) begin
      lif.load_valid = ($urandom % 4) == 0;
      lif.load_data  = 16'($urandom);
      blank_mask     = (($urandom % 3) == 0) ? 4'($urandom) : 4'b0000;
      step();
    end
    lif.load_valid = 1'b0;
    blank_mask = 4'b0000;

    // Asynchronous reset while a digit is driven and a value is pending.
    ok = 1'b0;
    for (int i = 0; i < 64 && !ok; i++) begin
      if (m_pend && ((t - 1) % TD) >= DC) ok = 1'b1;
      else begin
        lif.load_valid = !m_pend;
        lif.load_data  = 16'h9876;
        step();
      end
    end
    lif.load_valid = 1'b0;
    chk("drive_wait", 32'(ok), 32'h1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_seg", 32'(seg), 32'h7F);
    chk("async_an", 32'(an), 32'hF);
    chk("async_ready", 32'(lif.load_ready), 32'h1);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    repeat (40) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
